liteic_master_node_read: RTL and testbench

Master-side read node of the liteic crossbar: accepts AR requests from one AXI-Lite master, decodes the address to a slave slot, and drives the request into the crossbar request matrix. It collects the R response from the selected slave node and returns it to the master. Exactly one read is outstanding per node. This block is the initiator-side counterpart of the slave read node, which arbitrates between masters.

---
 rtl/liteic_pkg.sv | 28 ++
 rtl/liteic_addr_decoder.sv | 28 ++
 rtl/liteic_master_node_read.sv | 120 ++++++++++++
 tb/tb_liteic_master_node_read.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/liteic_pkg.sv
// liteic_pkg: shared crossbar sizing, slave address map, read connectivity, response codes and read-node FSM states.
package liteic_pkg;
    localparam int IC_NUM_SLAVE_SLOTS  = 4;
    localparam int IC_NUM_MASTER_SLOTS = 2;
    localparam int IC_ARADDR_WIDTH     = 32;
    localparam int IC_RDATA_WIDTH      = 34;
    localparam int IC_RDATA_W          = IC_RDATA_WIDTH - 2;
    localparam int IC_SLV_ID_W         = (IC_NUM_SLAVE_SLOTS > 1) ? $clog2(IC_NUM_SLAVE_SLOTS) : 1;
    // Slave 0 and slave 2 overlap on 0x2000-0x2FFF; slave 0 is hidden from master 1.
    localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_ARADDR_WIDTH-1:0] IC_SLV_BASE = {
        32'h8000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_2000};
    localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_ARADDR_WIDTH-1:0] IC_SLV_MASK = {
        32'hF000_0000, 32'hFFFF_E000, 32'h0000_F000, 32'hFFFF_F000};
    localparam logic [IC_NUM_SLAVE_SLOTS-1:0][IC_NUM_MASTER_SLOTS-1:0] IC_RD_CONN_MAP = {
        2'b11, 2'b11, 2'b11, 2'b01};
    localparam logic [1:0] IC_RESP_OKAY   = 2'b00;
    localparam logic [1:0] IC_RESP_DECERR = 2'b11;
    typedef logic [2:0] mst_rd_state_t;
    localparam mst_rd_state_t ST_IDLE  = 3'd0;
    localparam mst_rd_state_t ST_REQ   = 3'd1;
    localparam mst_rd_state_t ST_RESP  = 3'd2;
    localparam mst_rd_state_t ST_RDATA = 3'd3;
    localparam mst_rd_state_t ST_ERR   = 3'd4;
    function automatic logic [IC_NUM_SLAVE_SLOTS-1:0] ic_onehot(input logic [IC_SLV_ID_W-1:0] id);
        ic_onehot = '0;
        ic_onehot[id] = 1'b1;
    endfunction
endpackage

// File: rtl/liteic_addr_decoder.sv
// liteic_addr_decoder: combinational AR address decode to a slave slot for master MST_IDX.
// Ports: i_addr (address in), o_hit (some connected slave matches),
//        o_sel_onehot (one-hot slot, 0 on miss), o_sel_id (binary slot, 0 on miss).
module liteic_addr_decoder
    import liteic_pkg::*;
#(
    parameter int MST_IDX = 0
) (
    input  logic [IC_ARADDR_WIDTH-1:0]    i_addr,
    output logic                          o_hit,
    output logic [IC_NUM_SLAVE_SLOTS-1:0] o_sel_onehot,
    output logic [IC_SLV_ID_W-1:0]        o_sel_id
);
    // Scan downward so the lowest matching slot is the last one written and wins.
    always_comb begin
        o_hit        = 1'b0;
        o_sel_onehot = '0;
        o_sel_id     = '0;
        for (int s = IC_NUM_SLAVE_SLOTS - 1; s >= 0; s--) begin
            if (((i_addr & IC_SLV_MASK[s]) == IC_SLV_BASE[s]) && IC_RD_CONN_MAP[s][MST_IDX]) begin
                o_hit        = 1'b1;
                o_sel_onehot = '0;
                o_sel_onehot[s] = 1'b1;
                o_sel_id     = s[IC_SLV_ID_W-1:0];
            end
        end
    end
endmodule

// File: rtl/liteic_master_node_read.sv
// liteic_master_node_read: master-side read node; decodes AR, drives one crossbar request, returns the R response.
// Ports: clk_i/rst_i (sync active-high); mst_axil_* master AR/R channel; cbar_reqst_* request matrix
//        (broadcast address, one-hot valid, per-slave ready); cbar_resp_* response matrix
//        (per-slave {r_data, r_resp} and valid, one-hot ready).
// Option: LITEIC_MST_RD_DECERR_EN answers unmapped reads locally with DECERR; otherwise they
//         go to the last slave slot.
module liteic_master_node_read
    import liteic_pkg::*;
#(
    parameter int MST_IDX = 0
) (
    input  logic                                              clk_i,
    input  logic                                              rst_i,
    input  logic [IC_ARADDR_WIDTH-1:0]                        mst_axil_ar_addr_i,
    input  logic                                              mst_axil_ar_valid_i,
    output logic                                              mst_axil_ar_ready_o,
    output logic [IC_RDATA_W-1:0]                             mst_axil_r_data_o,
    output logic [1:0]                                        mst_axil_r_resp_o,
    output logic                                              mst_axil_r_valid_o,
    input  logic                                              mst_axil_r_ready_i,
    output logic [IC_ARADDR_WIDTH-1:0]                        cbar_reqst_data_o,
    output logic [IC_NUM_SLAVE_SLOTS-1:0]                     cbar_reqst_val_o,
    input  logic [IC_NUM_SLAVE_SLOTS-1:0]                     cbar_reqst_rdy_i,
    input  logic [IC_NUM_SLAVE_SLOTS-1:0][IC_RDATA_WIDTH-1:0] cbar_resp_data_i,
    input  logic [IC_NUM_SLAVE_SLOTS-1:0]                     cbar_resp_val_i,
    output logic [IC_NUM_SLAVE_SLOTS-1:0]                     cbar_resp_rdy_o
);
    mst_rd_state_t                   r_state;
    logic                            r_live;
    logic [IC_ARADDR_WIDTH-1:0]      r_addr;
    logic [IC_NUM_SLAVE_SLOTS-1:0]   r_sel;
    logic [IC_SLV_ID_W-1:0]          r_id;
    logic [IC_RDATA_W-1:0]           r_rdata;
    logic [1:0]                      r_rresp;
    logic                            w_hit;
    logic [IC_NUM_SLAVE_SLOTS-1:0]   w_dec_sel;
    logic [IC_SLV_ID_W-1:0]          w_dec_id;
    logic [IC_NUM_SLAVE_SLOTS-1:0]   w_sel;
    logic [IC_SLV_ID_W-1:0]          w_id;
    logic                            w_ar_hs;
    logic                            w_r_out;

    liteic_addr_decoder #(.MST_IDX(MST_IDX)) u_dec (
        .i_addr       (mst_axil_ar_addr_i),
        .o_hit        (w_hit),
        .o_sel_onehot (w_dec_sel),
        .o_sel_id     (w_dec_id)
    );

`ifdef LITEIC_MST_RD_DECERR_EN
    assign w_sel   = w_dec_sel;
    assign w_id    = w_dec_id;
    assign w_r_out = (r_state == ST_RDATA) || (r_state == ST_ERR);
`else
    // Unmapped reads fall through to the default slave in the last slot.
    assign w_sel   = w_hit ? w_dec_sel : ic_onehot(IC_SLV_ID_W'(IC_NUM_SLAVE_SLOTS - 1));
    assign w_id    = w_hit ? w_dec_id : IC_SLV_ID_W'(IC_NUM_SLAVE_SLOTS - 1);
    assign w_r_out = (r_state == ST_RDATA);
`endif

    // r_live keeps ar_ready low in the cycle right after a reset edge.
    assign mst_axil_ar_ready_o = r_live && (r_state == ST_IDLE);
    assign w_ar_hs             = mst_axil_ar_valid_i && mst_axil_ar_ready_o;
    assign mst_axil_r_valid_o  = w_r_out;
    assign mst_axil_r_data_o   = r_rdata;
    assign mst_axil_r_resp_o   = r_rresp;
    assign cbar_reqst_data_o   = r_addr;
    assign cbar_reqst_val_o    = (r_state == ST_REQ) ? r_sel : '0;
    assign cbar_resp_rdy_o     = (r_state == ST_RESP) ? r_sel : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_live  <= 1'b0;
            r_addr  <= '0;
            r_sel   <= '0;
            r_id    <= '0;
            r_rdata <= '0;
            r_rresp <= '0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_hs) begin
                        r_addr <= mst_axil_ar_addr_i;
                        r_sel  <= w_sel;
                        r_id   <= w_id;
`ifdef LITEIC_MST_RD_DECERR_EN
                        r_state <= w_hit ? ST_REQ : ST_ERR;
                        if (!w_hit) begin
                            r_rdata <= '0;
                            r_rresp <= IC_RESP_DECERR;
                        end
`else
                        r_state <= ST_REQ;
`endif
                    end
                end
                ST_REQ: begin
                    if (|(cbar_reqst_rdy_i & r_sel)) r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (cbar_resp_val_i[r_id]) begin
                        {r_rdata, r_rresp} <= cbar_resp_data_i[r_id];
                        r_state            <= ST_RDATA;
                    end
                end
                ST_RDATA: begin
                    if (mst_axil_r_ready_i) r_state <= ST_IDLE;
                end
`ifdef LITEIC_MST_RD_DECERR_EN
                ST_ERR: begin
                    if (mst_axil_r_ready_i) r_state <= ST_IDLE;
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_liteic_master_node_read.sv
// tb_liteic_master_node_read: directed bench with a response scoreboard for the master read node.
module tb_liteic_master_node_read;
    import liteic_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] ar_addr = '0;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic [31:0] rq_data;
    logic [3:0]  rq_val;
    logic [3:0]  rq_rdy = '0;
    logic [3:0][33:0] rs_data = '0;
    logic [3:0]  rs_val = '0;
    logic [3:0]  rs_rdy;
    logic [31:0] m1_ar_addr = '0;
    logic        m1_ar_valid = 1'b0;
    logic        m1_ar_ready;
    logic [31:0] m1_r_data;
    logic [1:0]  m1_r_resp;
    logic        m1_r_valid;
    logic [31:0] m1_rq_data;
    logic [3:0]  m1_rq_val;
    logic [3:0]  m1_rs_rdy;
    logic [3:0]  zero4 = '0;
    logic [3:0][33:0] zero_rs = '0;
    logic [33:0] exp_q[$];
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    liteic_master_node_read #(.MST_IDX(0)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .mst_axil_ar_addr_i(ar_addr), .mst_axil_ar_valid_i(ar_valid), .mst_axil_ar_ready_o(ar_ready),
        .mst_axil_r_data_o(r_data), .mst_axil_r_resp_o(r_resp), .mst_axil_r_valid_o(r_valid),
        .mst_axil_r_ready_i(r_ready),
        .cbar_reqst_data_o(rq_data), .cbar_reqst_val_o(rq_val), .cbar_reqst_rdy_i(rq_rdy),
        .cbar_resp_data_i(rs_data), .cbar_resp_val_i(rs_val), .cbar_resp_rdy_o(rs_rdy)
    );

    liteic_master_node_read #(.MST_IDX(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .mst_axil_ar_addr_i(m1_ar_addr), .mst_axil_ar_valid_i(m1_ar_valid), .mst_axil_ar_ready_o(m1_ar_ready),
        .mst_axil_r_data_o(m1_r_data), .mst_axil_r_resp_o(m1_r_resp), .mst_axil_r_valid_o(m1_r_valid),
        .mst_axil_r_ready_i(1'b0),
        .cbar_reqst_data_o(m1_rq_data), .cbar_reqst_val_o(m1_rq_val), .cbar_reqst_rdy_i(zero4),
        .cbar_resp_data_i(zero_rs), .cbar_resp_val_i(zero4), .cbar_resp_rdy_o(m1_rs_rdy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_ar(input logic [31:0] a);
        chk("ar_ready_before_ar", 64'(ar_ready), 64'd1);
        ar_addr  = a;
        ar_valid = 1'b1;
        tick;
        ar_valid = 1'b0;
    endtask

    task automatic take_r(input string tag);
        int n = 0;
        logic [33:0] e;
        while (!r_valid && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_rvalid"}, 64'(r_valid), 64'd1);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
        else begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, 64'({r_data, r_resp}), 64'(e));
        end
        chk({tag, "_ar_ready_busy"}, 64'(ar_ready), 64'd0);
        r_ready = 1'b1;
        tick;
        r_ready = 1'b0;
        chk({tag, "_ar_ready_after"}, 64'({ar_ready, r_valid}), 64'b10);
    endtask

    initial begin
        tick;
        tick;
        chk("rst_outputs", 64'({ar_ready, r_valid, r_data, r_resp, rq_val, rs_rdy}), 64'd0);
        chk("rst_reqst_data", 64'(rq_data), 64'd0);
        rst = 1'b0;
        tick;
        chk("ar_ready_after_rst", 64'({ar_ready, m1_ar_ready}), 64'b11);

        // Mapped read with zero wait states.
        rq_rdy = 4'b0010;
        rs_val = 4'b0010;
        rs_data[1] = {32'hDEAD_BEEF, IC_RESP_OKAY};
        exp_q.push_back({32'hDEAD_BEEF, IC_RESP_OKAY});
        do_ar(32'h0000_1004);
        chk("map_reqst_val_n1", 64'({rq_val, ar_ready}), 64'b0010_0);
        chk("map_reqst_data", 64'(rq_data), 64'h1004);
        tick;
        chk("map_resp_rdy_n2", 64'({rs_rdy, rq_val}), 64'b0010_0000);
        tick;
        chk("map_rvalid_n3", 64'(r_valid), 64'd1);
        rq_rdy = '0;
        rs_val = '0;
        take_r("map");

        // Request and response backpressure.
        do_ar(32'h0000_1008);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_hold", 64'({rq_val, rq_data, ar_ready}), 64'({4'b0010, 32'h1008, 1'b0}));
            tick;
        end
        rq_rdy = 4'b0010;
        tick;
        rq_rdy = '0;
        rs_val = 4'b0010;
        rs_data[1] = {32'hCAFE_F00D, 2'b01};
        exp_q.push_back({32'hCAFE_F00D, 2'b01});
        tick;
        rs_val = '0;
        rs_data[1] = '0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_r_hold", 64'({r_valid, r_data, r_resp, ar_ready}), 64'({1'b1, 32'hCAFE_F00D, 2'b01, 1'b0}));
            tick;
        end
        take_r("bp");

        // A response from an unselected slave is neither acknowledged nor captured.
        rq_rdy = 4'b0010;
        do_ar(32'h0000_1010);
        tick;
        rq_rdy = '0;
        rs_val = 4'b0001;
        rs_data[0] = {32'h55, IC_RESP_OKAY};
        chk("stray_resp_rdy", 64'(rs_rdy), 64'b0010);
        tick;
        chk("stray_ignored", 64'({r_valid, rs_rdy}), 64'b0_0010);
        rs_val = 4'b0010;
        rs_data[1] = {32'h66, IC_RESP_OKAY};
        exp_q.push_back({32'h66, IC_RESP_OKAY});
        tick;
        rs_val = '0;
        take_r("stray");

        // Unmapped address.
`ifdef LITEIC_MST_RD_DECERR_EN
        do_ar(32'hF000_0000);
        chk("decerr_rvalid_n1", 64'({r_valid, rq_val}), 64'b1_0000);
        exp_q.push_back({32'h0, IC_RESP_DECERR});
        take_r("decerr");
        chk("decerr_no_req", 64'(rq_val), 64'd0);
`else
        do_ar(32'hF000_0000);
        chk("unmapped_default_slot", 64'(rq_val), 64'b1000);
        rq_rdy = 4'b1000;
        tick;
        rq_rdy = '0;
        rs_val = 4'b1000;
        rs_data[3] = {32'h0BAD_0001, IC_RESP_OKAY};
        exp_q.push_back({32'h0BAD_0001, IC_RESP_OKAY});
        tick;
        rs_val = '0;
        take_r("unmapped");
`endif

        // Overlap on slaves 0 and 2; master 1 cannot reach slave 0.
        m1_ar_addr  = 32'h0000_2004;
        m1_ar_valid = 1'b1;
        do_ar(32'h0000_2004);
        m1_ar_valid = 1'b0;
        chk("overlap_lowest", 64'(rq_val), 64'b0001);
        chk("conn_skip_slave0", 64'(m1_rq_val), 64'b0100);
        rq_rdy = 4'b0001;
        tick;
        rq_rdy = '0;
        rs_val = 4'b0001;
        rs_data[0] = {32'hA0A0_0000, IC_RESP_OKAY};
        exp_q.push_back({32'hA0A0_0000, IC_RESP_OKAY});
        tick;
        rs_val = '0;
        take_r("overlap");

        // Reset while waiting for the response.
        rq_rdy = 4'b0010;
        do_ar(32'h0000_1020);
        tick;
        rq_rdy = '0;
        chk("rstmid_in_resp", 64'(rs_rdy), 64'b0010);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("rstmid_outputs", 64'({ar_ready, r_valid, r_data, r_resp, rq_val, rs_rdy, m1_rq_val}), 64'd0);
        chk("rstmid_reqst_data", 64'(rq_data), 64'd0);
        tick;
        chk("rstmid_ar_ready", 64'(ar_ready), 64'd1);
        rq_rdy = 4'b0010;
        rs_val = 4'b0010;
        rs_data[1] = {32'h1234_5678, IC_RESP_OKAY};
        exp_q.push_back({32'h1234_5678, IC_RESP_OKAY});
        do_ar(32'h0000_1030);
        tick;
        tick;
        rq_rdy = '0;
        rs_val = '0;
        take_r("post_rst");
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
